// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: port indices, priority
// mode encodings and the owner type used by the last-owner and response
// tracking registers.
package dmem_arbiter_pkg;

    // Port indices, usable directly as bit positions in a one-hot grant.
    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    // Encodings of the FIXED_PRIO parameter.
    localparam logic PRIO_ROUND_ROBIN = 1'b0;
    localparam logic PRIO_FIXED       = 1'b1;

    // Identifies which requester owns a slot (last winner, pending read).
    typedef enum logic {
        SEL_CPU    = 1'b0,
        SEL_LOADER = 1'b1
    } port_sel_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way chooser. Produces a one-hot (or empty) grant from
// the two request lines, the port that won last time, the priority mode and
// the loader lock. Only requesting ports are ever granted.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_owner,
    input  logic       fixed_prio,
    input  logic       lock,
    output logic [1:0] gnt
);

    // Lock beats everything; a lone requester wins; a tie goes to the
    // loader in fixed mode, otherwise to the port that did not win last.
    always_comb begin
        gnt = 2'b00;
        if (lock) begin
            gnt[PORT_LOADER] = req1;
        end else if (req0 && req1) begin
            if (fixed_prio == PRIO_FIXED || last_owner == PORT_CPU) begin
                gnt[PORT_LOADER] = 1'b1;
            end else begin
                gnt[PORT_CPU] = 1'b1;
            end
        end else begin
            gnt[PORT_CPU]    = req0;
            gnt[PORT_LOADER] = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous single-port BRAM (one-cycle
// read latency) between the CPU load/store path (port 0) and the UART
// loader (port 1). One transaction per cycle, response routed back to its
// owner the following cycle.
//
// Handshake: a port raises mX_req with its command; mX_gnt answers in the
// same cycle and the command is consumed at the next rising edge exactly
// when mX_req & mX_gnt. A refused port keeps its command stable and retries.
// Reads answer with a one-cycle mX_rvalid pulse the cycle after acceptance;
// there is no back-pressure on responses. Writes produce no response.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              m1_lock,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              conflict
);

    port_sel_e         last_owner;
    logic              lock_owner;
    logic              resp_valid;
    port_sel_e         resp_owner;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic [1:0]        pick;
    logic              gnt0;
    logic              gnt1;

    rr_pick2 u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_owner (last_owner),
        .fixed_prio (FIXED_PRIO != 0),
        .lock       (lock_owner),
        .gnt        (pick)
    );

    // Nothing is granted while reset is held, whatever the registers hold.
    assign gnt0     = pick[PORT_CPU] & rst;
    assign gnt1     = pick[PORT_LOADER] & rst;
    assign m0_gnt   = gnt0;
    assign m1_gnt   = gnt1;
    assign conflict = m0_req & m1_req & rst;

    // Route the winning port's command onto the memory; idle bus is all zero.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Track last winner, loader lock and the read that is in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner <= SEL_LOADER;
            lock_owner <= 1'b0;
            resp_valid <= 1'b0;
            resp_owner <= SEL_CPU;
        end else begin
            if (gnt0) begin
                last_owner <= SEL_CPU;
            end else if (gnt1) begin
                last_owner <= SEL_LOADER;
            end
            if (!m1_lock) begin
                lock_owner <= 1'b0;
            end else if (gnt1) begin
                lock_owner <= 1'b1;
            end
            resp_valid <= (gnt0 && !m0_we) || (gnt1 && !m1_we);
            resp_owner <= gnt1 ? SEL_LOADER : SEL_CPU;
        end
    end

    // A response pending across a reset edge is dropped, not delivered.
    assign m0_rvalid = resp_valid & (resp_owner == SEL_CPU) & rst;
    assign m1_rvalid = resp_valid & (resp_owner == SEL_LOADER) & rst;

    // Owner sees memory data live; the other port keeps its previous value.
    assign m0_rdata = m0_rvalid ? mem_rdata : m0_rdata_q;
    assign m1_rdata = m1_rvalid ? mem_rdata : m1_rdata_q;

    // Remember each port's most recent read data for the hold behaviour.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (m0_rvalid) begin
                m0_rdata_q <= mem_rdata;
            end
            if (m1_rvalid) begin
                m1_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Two instances (round-robin and fixed priority)
// see the same stimulus, each with its own write-first BRAM model. The
// driver predicts grants, memory drive and read responses from the arbiter
// rules and pushes them into queues; a negedge monitor pops and compares.
module tb_dmem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    typedef struct packed {
        int                c;
        logic              g0;
        logic              g1;
        logic              conf;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cyc_exp_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        int                port;
        int                cyc;
    } rsp_exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus and DUT wiring ----------------
    logic              m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;

    logic              m0_gnt [2];
    logic              m1_gnt [2];
    logic              m0_rvalid [2];
    logic              m1_rvalid [2];
    logic [DATA_W-1:0] m0_rdata [2];
    logic [DATA_W-1:0] m1_rdata [2];
    logic              mem_we [2];
    logic [ADDR_W-1:0] mem_addr [2];
    logic [DATA_W-1:0] mem_wdata [2];
    logic [DATA_W-1:0] mem_rdata [2];
    logic              conflict [2];

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
        .m1_lock(m1_lock),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .conflict(conflict[0])
    );

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
        .m1_lock(m1_lock),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .conflict(conflict[1])
    );

    // ---------------- memories ----------------
    logic [DATA_W-1:0] bram0 [int];
    logic [DATA_W-1:0] bram1 [int];
    logic [DATA_W-1:0] ref0 [int];
    logic [DATA_W-1:0] ref1 [int];

    function automatic logic [DATA_W-1:0] init_word(int a);
        if (a == 'h010) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    function automatic logic [DATA_W-1:0] bram_rd(int i, int a);
        if (i == 0) return bram0.exists(a) ? bram0[a] : init_word(a);
        return bram1.exists(a) ? bram1[a] : init_word(a);
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(int i, int a);
        if (i == 0) return ref0.exists(a) ? ref0[a] : init_word(a);
        return ref1.exists(a) ? ref1[a] : init_word(a);
    endfunction

    function automatic bit touched(int i, int a);
        if (i == 0) return bram0.exists(a) || ref0.exists(a);
        return bram1.exists(a) || ref1.exists(a);
    endfunction

    // Write-first single-port BRAM, one-cycle read latency.
    always @(posedge clk) begin
        mem_rdata[0] <= mem_we[0] ? mem_wdata[0] : bram_rd(0, int'(mem_addr[0]));
        mem_rdata[1] <= mem_we[1] ? mem_wdata[1] : bram_rd(1, int'(mem_addr[1]));
        if (mem_we[0]) bram0[int'(mem_addr[0])] = mem_wdata[0];
        if (mem_we[1]) bram1[int'(mem_addr[1])] = mem_wdata[1];
    end

    // ---------------- scoreboard queues ----------------
    cyc_exp_t cq0[$];
    cyc_exp_t cq1[$];
    rsp_exp_t rq0[$];
    rsp_exp_t rq1[$];

    function automatic void cq_push(int i, cyc_exp_t r);
        if (i == 0) cq0.push_back(r); else cq1.push_back(r);
    endfunction
    function automatic int cq_size(int i);
        return (i == 0) ? cq0.size() : cq1.size();
    endfunction
    function automatic cyc_exp_t cq_pop(int i);
        if (i == 0) return cq0.pop_front();
        return cq1.pop_front();
    endfunction
    function automatic void rq_push(int i, rsp_exp_t e);
        if (i == 0) rq0.push_back(e); else rq1.push_back(e);
    endfunction
    function automatic int rq_size(int i);
        return (i == 0) ? rq0.size() : rq1.size();
    endfunction
    function automatic rsp_exp_t rq_front(int i);
        if (i == 0) return rq0[0];
        return rq1[0];
    endfunction
    function automatic rsp_exp_t rq_pop(int i);
        if (i == 0) return rq0.pop_front();
        return rq1.pop_front();
    endfunction

    // ---------------- reference model ----------------
    int ref_last [2];
    bit ref_lock [2];

    // Instance 0 is round-robin, instance 1 is fixed priority.
    task automatic model_cycle(int i);
        cyc_exp_t r;
        rsp_exp_t e;
        int       w;
        w = -1;
        if (rst) begin
            if (ref_lock[i])              w = m1_req ? 1 : -1;
            else if (m0_req && m1_req)    w = (i == 1) ? 1 : (ref_last[i] == 0 ? 1 : 0);
            else if (m0_req)              w = 0;
            else if (m1_req)              w = 1;
        end
        r.c     = cyc;
        r.g0    = (w == 0);
        r.g1    = (w == 1);
        r.conf  = m0_req & m1_req & rst;
        r.we    = 1'b0;
        r.addr  = '0;
        r.wdata = '0;
        if (w == 0) begin
            r.we = m0_we; r.addr = m0_addr; r.wdata = m0_wdata;
        end else if (w == 1) begin
            r.we = m1_we; r.addr = m1_addr; r.wdata = m1_wdata;
        end
        cq_push(i, r);
        if (!rst) begin
            ref_last[i] = 1;
            ref_lock[i] = 1'b0;
            if (rq_size(i) > 0) begin
                e = rq_front(i);
                if (e.cyc == cyc) void'(rq_pop(i));
            end
        end else begin
            if (w >= 0) begin
                ref_last[i] = w;
                if (r.we) begin
                    if (i == 0) ref0[int'(r.addr)] = r.wdata;
                    else        ref1[int'(r.addr)] = r.wdata;
                end else begin
                    e.data = ref_rd(i, int'(r.addr));
                    e.port = w;
                    e.cyc  = cyc + 1;
                    rq_push(i, e);
                end
            end
            if (!m1_lock)    ref_lock[i] = 1'b0;
            else if (w == 1) ref_lock[i] = 1'b1;
        end
    endtask

    // ---------------- monitor / checker ----------------
    int                n_checks = 0;
    int                n_fail = 0;
    logic [DATA_W-1:0] hold [2][2];
    bit                sweep_req = 1'b0;
    bit                sweep_done = 1'b0;

    task automatic chk(string name, int i, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got 0x%0h, expected 0x%0h", name, i, cyc, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            hold[i][0] = '0;
            hold[i][1] = '0;
            ref_last[i] = 1;
            ref_lock[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        cyc_exp_t r;
        rsp_exp_t e;
        bit       due;
        for (int i = 0; i < 2; i++) begin
            if (cq_size(i) > 0) begin
                r = cq_pop(i);
                chk("m0_gnt", i, 32'(m0_gnt[i]), 32'(r.g0));
                chk("m1_gnt", i, 32'(m1_gnt[i]), 32'(r.g1));
                chk("conflict", i, 32'(conflict[i]), 32'(r.conf));
                chk("mem_we", i, 32'(mem_we[i]), 32'(r.we));
                chk("mem_addr", i, 32'(mem_addr[i]), 32'(r.addr));
                chk("mem_wdata", i, mem_wdata[i], r.wdata);
            end
            due = 1'b0;
            if (rq_size(i) > 0) begin
                e = rq_front(i);
                due = (e.cyc == cyc);
            end
            if (due) begin
                e = rq_pop(i);
                if (e.port == 0) begin
                    chk("m0_rvalid", i, 32'(m0_rvalid[i]), 32'd1);
                    chk("m0_rdata", i, m0_rdata[i], e.data);
                    chk("m1_rvalid_idle", i, 32'(m1_rvalid[i]), 32'd0);
                    chk("m1_rdata_hold", i, m1_rdata[i], hold[i][1]);
                    hold[i][0] = e.data;
                end else begin
                    chk("m1_rvalid", i, 32'(m1_rvalid[i]), 32'd1);
                    chk("m1_rdata", i, m1_rdata[i], e.data);
                    chk("m0_rvalid_idle", i, 32'(m0_rvalid[i]), 32'd0);
                    chk("m0_rdata_hold", i, m0_rdata[i], hold[i][0]);
                    hold[i][1] = e.data;
                end
            end else begin
                chk("m0_rvalid_idle", i, 32'(m0_rvalid[i]), 32'd0);
                chk("m1_rvalid_idle", i, 32'(m1_rvalid[i]), 32'd0);
                if (rst) begin
                    chk("m0_rdata_hold", i, m0_rdata[i], hold[i][0]);
                    chk("m1_rdata_hold", i, m1_rdata[i], hold[i][1]);
                end
            end
            if (!rst) begin
                hold[i][0] = '0;
                hold[i][1] = '0;
            end
        end
        if (sweep_req && !sweep_done) begin
            for (int i = 0; i < 2; i++) begin
                chk("resp_drain", i, 32'(rq_size(i)), 32'd0);
                for (int a = 0; a < 'h200; a++) begin
                    if (touched(i, a)) chk($sformatf("mem_word@%0h", a), i, bram_rd(i, a), ref_rd(i, a));
                end
            end
            sweep_done = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r0, input logic w0, input int a0, input logic [DATA_W-1:0] d0,
                         input logic r1, input logic w1, input int a1, input logic [DATA_W-1:0] d1,
                         input logic lk);
        m0_req = r0; m0_we = w0; m0_addr = ADDR_W'(a0); m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = ADDR_W'(a1); m1_wdata = d1;
        m1_lock = lk;
    endtask

    task automatic tick();
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        drive(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic do_reset(int n);
        rst = 1'b0;
        idle(n);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lock_left;
        lock_left = 0;
        @(posedge clk);
        #1;
        do_reset(2);

        // single read of preloaded word
        drive(1'b1, 1'b0, 'h010, '0, 1'b0, 1'b0, 0, '0, 1'b0);
        tick();
        idle(1);

        // tie storm right after reset: alternates in round-robin mode
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 'h010 + k, '0, 1'b1, 1'b0, 'h030 + k, '0, 1'b0);
            tick();
        end
        idle(1);

        // three-cycle tie then loader drops out
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 'h004, '0, 1'b1, 1'b0, 'h008 + k, '0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 'h004, '0, 1'b0, 1'b0, 0, '0, 1'b0);
        tick();
        idle(1);

        // locked loader burst with the CPU requesting throughout
        drive(1'b1, 1'b0, 'h005, '0, 1'b0, 1'b0, 0, '0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 'h006, '0, 1'b1, 1'b1, 'h100 + k, 32'h5A00_0000 + 32'(k), 1'b1);
            tick();
        end
        drive(1'b1, 1'b0, 'h006, '0, 1'b0, 1'b0, 0, '0, 1'b0);
        tick();
        tick();
        idle(1);

        // write from loader then read back from CPU
        drive(1'b0, 1'b0, 0, '0, 1'b1, 1'b1, 'h020, 32'h0000_00AB, 1'b0);
        tick();
        drive(1'b1, 1'b0, 'h020, '0, 1'b0, 1'b0, 0, '0, 1'b0);
        tick();
        idle(1);

        // reset while a read is in flight, then a tie
        drive(1'b1, 1'b0, 'h010, '0, 1'b0, 1'b0, 0, '0, 1'b0);
        tick();
        do_reset(1);
        drive(1'b1, 1'b0, 'h011, '0, 1'b1, 1'b0, 'h012, '0, 1'b0);
        tick();
        idle(1);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (lock_left == 0 && $urandom_range(0, 15) == 0) lock_left = $urandom_range(2, 6);
            m1_lock = (lock_left > 0);
            if (lock_left > 0) lock_left--;
            m0_req   = ($urandom_range(0, 3) != 0);
            m0_we    = 1'($urandom_range(0, 1));
            m0_addr  = ADDR_W'($urandom_range(0, 47));
            m0_wdata = $urandom;
            m1_req   = ($urandom_range(0, 2) != 0);
            m1_we    = 1'($urandom_range(0, 1));
            m1_addr  = ADDR_W'($urandom_range(0, 47));
            m1_wdata = $urandom;
            tick();
        end
        rst = 1'b1;
        idle(3);

        sweep_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
